// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared constants for the 1011 serial pattern detector.
//   STATE_W  - width of the exported debug state encoding
//   state_t  - FSM state encodings S0..S4 (3-bit constants)
//   PATTERN  - the detected pattern; bit [3] is received first
package seq_detect_pkg;

  localparam int STATE_W = 3;

  // S0 = no prefix, S1 = "1", S2 = "10", S3 = "101", S4 = "1011"
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage : seq_detect_pkg

// File: rtl/seq_detect_1011_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears q
//   clr   - synchronous clear, has priority over inc
//   inc   - add one to q on this edge unless already at the maximum
//   q     - current count, sticks at 2^CNT_W-1
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != MAX_VAL)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/seq_detect_1011.sv
// seq_detect_1011
// Serial detector for the pattern 1,0,1,1 (first bit first), overlapping
// matches allowed. Moore FSM plus a registered match pulse and a saturating
// match counter. All outputs come straight from registers.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   d       - serial data bit
//   d_valid - d is consumed only on edges where this is 1
//   clr     - synchronous clear of FSM, match and counter (beats d_valid)
//   match   - one-cycle pulse after the edge that enters S4
//   count   - detections since reset/clr, saturating
//   state   - current FSM state encoding, for debug
module seq_detect_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             d_valid,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  import seq_detect_pkg::*;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_match;
  logic             w_hit;
  logic [CNT_W-1:0] w_count;

  // State register and match pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_match <= 1'b0;
    end else if (clr) begin
      r_state <= S0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_hit;
    end
  end

  // Next-state logic. On a mismatch each state falls back to the longest
  // suffix of the received bits that is still a prefix of the pattern.
  always_comb begin
    w_state_next = r_state;
    w_hit        = 1'b0;
    if (d_valid) begin
      case (r_state)
        S0:      w_state_next = (d == PATTERN[3]) ? S1 : S0;
        S1:      w_state_next = (d == PATTERN[2]) ? S2 : S1;
        S2:      w_state_next = (d == PATTERN[1]) ? S3 : S0;
        S3:      w_state_next = (d == PATTERN[0]) ? S4 : S2;
        S4:      w_state_next = d ? S1 : S2;
        default: w_state_next = S0;
      endcase
      // S4 can only be entered from S3, so idling in S4 never re-fires.
      w_hit = (w_state_next == S4);
    end
  end

  // Counter sees clr itself, so it needs no extra gating of inc.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_hit),
    .q     (w_count)
  );

  assign match = r_match;
  assign count = w_count;
  assign state = r_state;

endmodule : seq_detect_1011

// File: tb/tb_seq_detect_1011.sv
// tb_seq_detect_1011
// Directed bench for seq_detect_1011. Two instances share the stimulus:
// dut uses the default CNT_W=8, dut_s uses CNT_W=2 for saturation checks.
module tb_seq_detect_1011;

  logic       clk;
  logic       rst_n;
  logic       d;
  logic       d_valid;
  logic       clr;
  logic       match;
  logic [7:0] count;
  logic [2:0] state;
  logic       match_s;
  logic [1:0] count_s;
  logic [2:0] state_s;

  int total;
  int bad;

  // expected values for the overlap stream 1,0,1,1,0,1,1
  logic       ov_d    [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0] ov_st   [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
  logic       ov_m    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] ov_c    [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
  // expected small-counter values after each of six matches
  logic [1:0] sat_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  seq_detect_1011 #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .d_valid (d_valid),
    .clr     (clr),
    .match   (match),
    .count   (count),
    .state   (state)
  );

  seq_detect_1011 #(.CNT_W(2)) dut_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .d_valid (d_valid),
    .clr     (clr),
    .match   (match_s),
    .count   (count_s),
    .state   (state_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, return 1 time unit after it.
  task automatic step(input logic c, input logic v, input logic b);
    clr     = c;
    d_valid = v;
    d       = b;
    @(posedge clk);
    #1;
    $display("t=%0t clr=%0b d_valid=%0b d=%0b -> state=%0d match=%0b count=%0d count_s=%0d",
             $time, c, v, b, state, match, count, count_s);
    clr     = 1'b0;
    d_valid = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    d       = 1'b0;
    d_valid = 1'b0;
    clr     = 1'b0;

    // Reset takes effect without a clock edge
    #2;
    check("rst_state", state, 3'd0);
    check("rst_match", match, 1'b0);
    check("rst_count", count, 8'd0);
    check("rst_count_s", count_s, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 1011 detection, match one cycle after 4th bit
    step(1'b0, 1'b1, 1'b1); check("b1_state", state, 3'd1);
    step(1'b0, 1'b1, 1'b0); check("b2_state", state, 3'd2);
    step(1'b0, 1'b1, 1'b1); check("b3_state", state, 3'd3);
    check("b3_match", match, 1'b0);
    step(1'b0, 1'b1, 1'b1); check("b4_state", state, 3'd4);
    check("b4_match", match, 1'b1);
    check("b4_count", count, 8'd1);
    // idling in S4 does not re-fire
    step(1'b0, 1'b0, 1'b1); check("idle_state", state, 3'd4);
    check("idle_match", match, 1'b0);
    check("idle_count", count, 8'd1);

    // Overlapping matches
    step(1'b1, 1'b0, 1'b0);
    check("clr_state", state, 3'd0);
    check("clr_count", count, 8'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, ov_d[i]);
      check($sformatf("ov%0d_state", i), state, ov_st[i]);
      check($sformatf("ov%0d_match", i), match, ov_m[i]);
      check($sformatf("ov%0d_count", i), count, ov_c[i]);
    end

    // Gap of invalid cycles mid-pattern, with d=1 held during the gap
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check($sformatf("gap%0d_state", i), state, 3'd3);
      check($sformatf("gap%0d_match", i), match, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1);
    check("gap_end_match", match, 1'b1);
    check("gap_end_count", count, 8'd1);

    // Saturation with CNT_W=2: 1011 then five more overlapping 011
    step(1'b1, 1'b0, 1'b0);
    check("sat_clr_count_s", count_s, 2'd0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("sat0_match_s", match_s, 1'b1);
    check("sat0_count_s", count_s, sat_exp[0]);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check($sformatf("sat%0d_match_s", i), match_s, 1'b1);
      check($sformatf("sat%0d_count_s", i), count_s, sat_exp[i]);
      check($sformatf("sat%0d_count", i), count, 32'(i + 1));
    end

    // clr with d_valid=1,d=1 while in S3: clr wins
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("pre_clr_state", state, 3'd3);
    check("pre_clr_count", count, 8'd6);
    step(1'b1, 1'b1, 1'b1);
    check("clrpri_state", state, 3'd0);
    check("clrpri_count", count, 8'd0);
    check("clrpri_count_s", count_s, 2'd0);
    check("clrpri_match", match, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("clrpri_match2", match, 1'b0);

    // Async reset mid-pattern in S3, then a lone 1 must not match
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("prerst_state", state, 3'd3);
    check("prerst_count", count, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 3'd0);
    check("arst_count", count, 8'd0);
    check("arst_match", match, 1'b0);
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check("postrst_state", state, 3'd1);
    check("postrst_match", match, 1'b0);
    check("postrst_count", count, 8'd0);
    step(1'b0, 1'b0, 1'b0);
    check("postrst_match2", match, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_detect_1011

// File: doc/seq_detect_1011.md
SEQ_DETECT_1011 -- requirements
Module: seq_detect_1011

Interface
REQ-001 Parameter: CNT_W, default 8, width of the match counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: d  input  1  serial data bit from the upstream flip-flop stage.
REQ-005 Port: d_valid  input  1  qualifies d; the bit is consumed only on edges where d_valid=1.
REQ-006 Port: clr  input  1  synchronous clear of the detector state and the match counter.
REQ-007 Port: match  output  1  registered one-cycle pulse on each detection of 1011.
REQ-008 Port: count  output  CNT_W  number of detections since reset or clr, saturating.
REQ-009 Port: state  output  3  current FSM state encoding, for debug.

Function
REQ-010 The block SHALL detect the serial pattern 1,0,1,1 (first bit received first), with overlapping matches allowed.
REQ-011 The block SHALL implement a Moore FSM with the states S0=idle/no prefix, S1="1", S2="10", S3="101" and S4="1011".
REQ-012 The block SHALL apply these transitions on edges with d_valid=1 (d=0 / d=1):
- S0: S0 / S1
- S1: S2 / S1
- S2: S0 / S3
- S3: S2 / S4
- S4: S2 / S1
REQ-013 The block SHALL hold the state unchanged on edges with d_valid=0.
REQ-014 The block SHALL register match to 1 for exactly the one cycle following the edge that moves the FSM into S4, and to 0 otherwise, including while the FSM idles in S4.
REQ-015 The block SHALL increment count by 1 on the same edge that sets match.
REQ-016 count SHALL saturate at 2^CNT_W-1, with no wrap-around to 0.
REQ-017 When clr=1 on an edge, the block SHALL force state to S0, count to 0 and match to 0, and SHALL ignore d_valid on that edge (clr has priority).
REQ-018 The match latency SHALL be one clock from the edge sampling the final 1 of the pattern.
REQ-019 The block SHALL have no combinational path from any input to any output.

Reset
REQ-020 When rst_n=0, the block SHALL immediately, without waiting for clk, force state=S0, match=0 and count=0.
REQ-021 Reset asserted mid-pattern (e.g. in S3) SHALL discard the partial prefix, so a following single 1 SHALL NOT produce a match.
REQ-022 On the first rising clk edge after rst_n deasserts, the block SHALL process d and d_valid normally.

Structure
REQ-023 The state encodings S0..S4 (3-bit constants) and the pattern constant 4'b1011 SHALL reside in a shared package, seq_detect_pkg.
REQ-024 The saturating counter SHALL be implemented as the sub-module sat_counter, with the ports clk, rst_n, clr, inc, and q[CNT_W-1:0].
REQ-025 The FSM state register, the match register and the counter SHALL all use the same asynchronous active-low reset.

Verification
REQ-026 Stimulus: reset, then d_valid=1 with d=1,0,1,1 on consecutive edges -> required response: match=1 for one cycle after the 4th edge, count=1, state=S4.
REQ-027 Stimulus: stream 1,0,1,1,0,1,1 -> required response: two match pulses (after bits 4 and 7), count=2 (overlap).
REQ-028 Stimulus: 1,0,1 then d_valid=0 for 5 cycles, then 1 -> required response: match after the final bit; no match during the gap.
REQ-029 Stimulus: CNT_W=2, six matches -> required response: count goes 1,2,3,3,3,3.
REQ-030 Stimulus: clr and d_valid=1 with d=1 on the same edge while in S3 -> required response: state=S0, count=0, no match.
REQ-031 Stimulus: rst_n pulsed low between clock edges while in S3 -> required response: outputs zero immediately; a subsequent single 1 yields no match.
